seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter, the source end of the serial-bit sequence-detector path. On a start request it latches a PAT_W-bit pattern and emits it MSB-first, one bit per clk, a programmable number of times, separated by programmable runs of zero gap bits. Its bit_out/bit_valid pair drives the 1010 non-overlapping detectors directly, both in the datapath and as a stimulus source in detector benches. Pauses via hold and reports completion with a done pulse and a frame count.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
PAT_DEFAULT, 4'b1010, pattern used when use_default=1
CNT_W, 8, width of repeat_cnt and frames_sent
GAP_W, 4, width of gap_len

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
use_default  in  1  1: send PAT_DEFAULT; 0: send pattern
pattern  in  PAT_W  user pattern, MSB sent first
repeat_cnt  in  CNT_W  number of pattern copies; 0 = send nothing
gap_len  in  GAP_W  zero bits inserted between copies
hold  in  1  stall; freezes the FSM and all counters
bit_out  out  1  serial data
bit_valid  out  1  bit_out is a real stream bit this cycle
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
frames_sent  out  CNT_W  copies fully sent in the current or last job

Behaviour:
- Reset: synchronous, active-high, on clk. While rst=1 at an edge, all outputs go to 0, the FSM goes to IDLE and all internal counters clear. Reset mid-job aborts the job; no done pulse.
- FSM states: IDLE, SEND, GAP, FIN. All outputs are registered.
- IDLE:
  - On start=1, latch the pattern (PAT_DEFAULT if use_default=1), repeat_cnt and gap_len.
  - Clear frames_sent and the bit index; set busy=1.
  - If repeat_cnt=0 go to FIN; otherwise go to SEND.
  - Later changes on the inputs do not affect the running job.
- SEND:
  - Each non-hold cycle, bit_out=pat[PAT_W-1-idx] and bit_valid=1.
  - The first bit appears in the cycle immediately after the start edge (latency 1).
  - After bit PAT_W-1, frames_sent increments in that same update.
  - If frames_sent+1 == repeat_cnt, go to FIN.
  - Else if gap_len=0, start the next copy in SEND back-to-back.
  - Else go to GAP.
- GAP: emit gap_len cycles of bit_out=0, bit_valid=1, then return to SEND with idx=0. No gap follows the last copy.
- FIN: done=1 for exactly one cycle, busy=0, bit_valid=0, then IDLE.
- IDLE outputs: bit_valid=0, bit_out=0, busy=0. frames_sent holds its last value until the next start.
- hold=1: state, idx, gap counter and frames_sent are frozen; bit_valid=0 and bit_out holds its value. On release, resume with the same bit (nothing skipped or duplicated). hold is ignored in IDLE and FIN.
- start while busy: ignored. start in the FIN cycle: ignored. start one cycle after done: accepted.
- Total valid bits per job = repeat_cnt*PAT_W + (repeat_cnt-1)*gap_len, for repeat_cnt>=1.
- Counters wrap-free: repeat_cnt max is 2^CNT_W-1, and frames_sent never exceeds repeat_cnt.

Decomposition:
- Shared package seq_pkg:
  - FSM state encoding typedef.
  - PAT_DEFAULT_1010 constant.
  - The same pattern constant is used by the detector family.
- One natural sub-module, seq_gap_counter: loadable down-counter with hold and zero flag. It is used for both the bit index and the gap run.

Test Plan:
- Default job: use_default=1, repeat_cnt=1, gap_len=0, start at cycle 0 -> bit_valid=1 for cycles 1..4 with bits 1,0,1,0; done at cycle 5; frames_sent=1.
- Repeats with gap: pattern=4'b1100, repeat_cnt=3, gap_len=2 -> stream 1100 00 1100 00 1100 (16 valid bits); done once; frames_sent=3. A connected 1010 detector asserts 0 times.
- Back-to-back default: repeat_cnt=2, gap_len=0 -> 10101010; a non-overlapping 1010 detector pulses twice.
- Hold mid-pattern: hold=1 for 3 cycles after the 2nd bit -> bit_valid=0 for those 3 cycles; the resumed stream is still 1,0,1,0 and done is delayed by 3 cycles.
- repeat_cnt=0: no valid bits; done at cycle 1; frames_sent=0. start asserted during busy in another job -> no effect.
- rst during GAP of a 3-copy job -> next cycle all outputs 0 and no done; a new start afterward runs a full, correct job.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the 1010 detector family.
// Holds the transmitter state encoding and the default pattern constant.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } tx_state_t;

    localparam logic [3:0] PAT_DEFAULT_1010 = 4'b1010;

endpackage

// File: rtl/seq_gap_counter.sv
// Loadable down-counter with hold and a zero flag.
// Serves as both the bit-index counter and the gap-run counter of the transmitter.
module seq_gap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load wins over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            if (load) begin
                count <= load_val;
            end else if (dec && (count != '0)) begin
                count <= count - 1'b1;
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first a programmable
// number of times, with zero-bit gaps between copies, a hold stall and a done pulse.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_DEFAULT_1010,
    parameter int               CNT_W       = 8,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             hold,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    tx_state_t        state;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;

    logic [IDX_W-1:0] idx_cnt;
    logic [IDX_W-1:0] idx_next;
    logic             idx_zero;
    logic             idx_load;
    logic             idx_dec;

    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_load_val;
    logic             gap_zero;
    logic             gap_load;
    logic             gap_dec;

    logic             hold_eff;
    logic             last_frame;
    logic [PAT_W-1:0] pat_sel;

    assign pat_sel      = use_default ? PAT_DEFAULT : pattern;
    assign hold_eff     = hold && ((state == ST_SEND) || (state == ST_GAP));
    assign last_frame   = ((frames_sent + CNT_W'(1)) == rep_q);
    assign idx_next     = idx_cnt - 1'b1;
    assign gap_load_val = gap_q - 1'b1;

    // idx_cnt always names the pattern bit currently on bit_out; the gap
    // counter holds the number of gap cycles still to come after this one.
    always_comb begin
        idx_load = 1'b0;
        idx_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    idx_load = 1'b1;
                end
            end
            ST_SEND: begin
                if (!hold) begin
                    if (idx_zero) begin
                        if (!last_frame) begin
                            if (gap_q == '0) begin
                                idx_load = 1'b1;
                            end else begin
                                gap_load = 1'b1;
                            end
                        end
                    end else begin
                        idx_dec = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!hold) begin
                    if (gap_zero) begin
                        idx_load = 1'b1;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    seq_gap_counter #(.W(IDX_W)) u_idx_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (IDX_LAST),
        .dec      (idx_dec),
        .hold     (hold_eff),
        .count    (idx_cnt),
        .zero     (idx_zero)
    );

    seq_gap_counter #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (gap_load_val),
        .dec      (gap_dec),
        .hold     (hold_eff),
        .count    (gap_cnt),
        .zero     (gap_zero)
    );

    // Outputs are registered alongside the state, so each update sets what
    // the stream shows during the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        pat_q       <= pat_sel;
                        rep_q       <= repeat_cnt;
                        gap_q       <= gap_len;
                        frames_sent <= '0;
                        if (repeat_cnt == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_SEND;
                            busy      <= 1'b1;
                            bit_out   <= pat_sel[PAT_W-1];
                            bit_valid <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (hold) begin
                        bit_valid <= 1'b0;
                    end else if (idx_zero) begin
                        frames_sent <= frames_sent + CNT_W'(1);
                        if (last_frame) begin
                            state     <= ST_FIN;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b0;
                        end else if (gap_q == '0) begin
                            bit_out   <= pat_q[PAT_W-1];
                            bit_valid <= 1'b1;
                        end else begin
                            state     <= ST_GAP;
                            bit_out   <= 1'b0;
                            bit_valid <= 1'b1;
                        end
                    end else begin
                        bit_out   <= pat_q[idx_next];
                        bit_valid <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (hold) begin
                        bit_valid <= 1'b0;
                    end else if (gap_zero) begin
                        state     <= ST_SEND;
                        bit_out   <= pat_q[PAT_W-1];
                        bit_valid <= 1'b1;
                    end else begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    bit_out   <= 1'b0;
                    bit_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
